// File: rtl/mem_arbiter_if.sv
// Single-transaction memory request/response port: valid/ready request plus a one-cycle rvalid response.
// master = side issuing requests, slave = side accepting them and returning responses.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned MASK_W = DATA_W / 8;

    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    modport master (output valid, addr, wen, wdata, wmask, input ready, rdata, rvalid);
    modport slave  (input valid, addr, wen, wdata, wmask, output ready, rdata, rvalid);
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and the LSU, one transaction at a time.
// Define ARB_RR_EN for round-robin arbitration; default is fixed LSU-over-IFU priority.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  ifu_bus,
    mem_arbiter_if.slave  lsu_bus,
    mem_arbiter_if.master mem_bus
);
    localparam int unsigned MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_e;
    typedef enum logic {OWN_IFU, OWN_LSU} owner_e;

    state_e state_q, state_d;
    owner_e owner_q, owner_d;
    owner_e winner;
    logic   any_valid;
    logic   pick_lsu;
    logic   grant;

    logic [ADDR_W-1:0] sel_addr;
    logic              sel_wen;
    logic [DATA_W-1:0] sel_wdata;
    logic [MASK_W-1:0] sel_wmask;

    // Fetch is read-only; its write fields are intentionally ignored.
    logic unused_ifu;
    assign unused_ifu = ^{ifu_bus.wen, ifu_bus.wdata, ifu_bus.wmask};

    assign any_valid = ifu_bus.valid | lsu_bus.valid;
    assign winner    = pick_lsu ? OWN_LSU : OWN_IFU;

`ifdef ARB_RR_EN
    owner_e last_q, last_d;

    // On contention the requester that did not own the previous grant wins.
    assign pick_lsu = lsu_bus.valid & (~ifu_bus.valid | (last_q == OWN_IFU));
    assign last_d   = grant ? winner : last_q;

    always_ff @(posedge clk) begin
        if (rst) last_q <= OWN_IFU;
        else     last_q <= last_d;
    end
`else
    assign pick_lsu = lsu_bus.valid;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_IFU;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_wen   = 1'b0;
        sel_wdata = '0;
        sel_wmask = '0;
        if (owner_q == OWN_LSU) begin
            sel_addr  = lsu_bus.addr;
            sel_wen   = lsu_bus.wen;
            sel_wdata = lsu_bus.wdata;
            sel_wmask = lsu_bus.wmask;
        end else begin
            sel_addr  = ifu_bus.addr;
        end
    end

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        grant           = 1'b0;
        mem_bus.valid   = 1'b0;
        mem_bus.addr    = '0;
        mem_bus.wen     = 1'b0;
        mem_bus.wdata   = '0;
        mem_bus.wmask   = '0;
        ifu_bus.ready   = 1'b0;
        ifu_bus.rvalid  = 1'b0;
        ifu_bus.rdata   = '0;
        lsu_bus.ready   = 1'b0;
        lsu_bus.rvalid  = 1'b0;
        lsu_bus.rdata   = '0;

        // Outputs stay quiet while reset is asserted, even mid-transaction.
        if (!rst) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (any_valid) begin
                        grant   = 1'b1;
                        owner_d = winner;
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    mem_bus.valid = 1'b1;
                    mem_bus.addr  = sel_addr;
                    mem_bus.wen   = sel_wen;
                    mem_bus.wdata = sel_wdata;
                    mem_bus.wmask = sel_wmask;
                    if (owner_q == OWN_LSU) begin
                        lsu_bus.ready = mem_bus.ready;
                        if (lsu_bus.valid && mem_bus.ready) state_d = ST_RESP;
                    end else begin
                        ifu_bus.ready = mem_bus.ready;
                        if (ifu_bus.valid && mem_bus.ready) state_d = ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (mem_bus.rvalid) begin
                        if (owner_q == OWN_LSU) begin
                            lsu_bus.rvalid = 1'b1;
                            lsu_bus.rdata  = mem_bus.rdata;
                        end else begin
                            ifu_bus.rvalid = 1'b1;
                            ifu_bus.rdata  = mem_bus.rdata;
                        end
                        if (any_valid) begin
                            grant   = 1'b1;
                            owner_d = winner;
                            state_d = ST_REQ;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end
endmodule
